// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared definitions for the EX forwarding / load-use hazard unit and the EX operand muxes.
package forwarding_hazard_unit_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_e;

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// ID/EX-side signals of the forwarding/hazard unit; the pipeline is master, the unit is slave.
interface forwarding_hazard_unit_if #(
    parameter int REG_ADDR_W = forwarding_hazard_unit_pkg::REG_ADDR_W,
    parameter int CNT_W      = 32
);
    logic                  i_enable;
    logic                  i_flush;
    logic [REG_ADDR_W-1:0] i_rs_id;
    logic [REG_ADDR_W-1:0] i_rt_id;
    logic                  i_use_rt_id;
    logic [REG_ADDR_W-1:0] i_rd_rt_ex;
    logic                  i_regwrite_ex;
    logic                  i_memread_ex;
    logic [1:0]            o_cortocircuitoA;
    logic [1:0]            o_cortocircuitoB;
    logic                  o_stall;
    logic                  o_bubble;
    logic [CNT_W-1:0]      o_stall_count;

    modport master (
        output i_enable, i_flush, i_rs_id, i_rt_id, i_use_rt_id,
               i_rd_rt_ex, i_regwrite_ex, i_memread_ex,
        input  o_cortocircuitoA, o_cortocircuitoB, o_stall, o_bubble, o_stall_count
    );

    modport slave (
        input  i_enable, i_flush, i_rs_id, i_rt_id, i_use_rt_id,
               i_rd_rt_ex, i_regwrite_ex, i_memread_ex,
        output o_cortocircuitoA, o_cortocircuitoB, o_stall, o_bubble, o_stall_count
    );
endinterface

// File: rtl/forwarding_hazard_unit_fwd_select.sv
// Forwarding select for one ID source operand against the shadow EX and MEM destinations.
module fwd_select #(
    parameter int ADDR_W = forwarding_hazard_unit_pkg::REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] x,
    input  logic [ADDR_W-1:0] ex_dst,
    input  logic              ex_wr,
    input  logic              ex_memread,
    input  logic [ADDR_W-1:0] mem_dst,
    input  logic              mem_wr,
    output logic [1:0]        sel
);
    import forwarding_hazard_unit_pkg::*;

    // A load in EX has no ALU result to forward; the stall path handles it instead.
    always_comb begin
        sel = FWD_REG;
        if (ex_wr && !ex_memread && (x != '0) && (ex_dst == x)) begin
            sel = FWD_MEM;
        end else if (mem_wr && (x != '0) && (mem_dst == x)) begin
            sel = FWD_WB;
        end
    end
endmodule

// File: rtl/forwarding_hazard_unit.sv
// Registered EX forwarding selects plus single-cycle load-use stall/bubble generation.
module forwarding_hazard_unit #(
    parameter int REG_ADDR_W = forwarding_hazard_unit_pkg::REG_ADDR_W,
    parameter int CNT_W      = 32
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    forwarding_hazard_unit_if.slave  bus
);
    import forwarding_hazard_unit_pkg::*;

    state_e                state_q, state_d;
    logic [REG_ADDR_W-1:0] mem_dst_q, mem_dst_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [REG_ADDR_W-1:0] wb_dst_q, wb_dst_d;
    logic                  wb_wr_q, wb_wr_d;
    logic [1:0]            sel_a_q, sel_a_d;
    logic [1:0]            sel_b_q, sel_b_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic       hazard;
    logic       stall;
    logic [1:0] sel_a_c;
    logic [1:0] sel_b_c;

    fwd_select #(.ADDR_W(REG_ADDR_W)) u_sel_a (
        .x(bus.i_rs_id), .ex_dst(bus.i_rd_rt_ex), .ex_wr(bus.i_regwrite_ex),
        .ex_memread(bus.i_memread_ex), .mem_dst(mem_dst_q), .mem_wr(mem_wr_q),
        .sel(sel_a_c)
    );

    fwd_select #(.ADDR_W(REG_ADDR_W)) u_sel_b (
        .x(bus.i_rt_id), .ex_dst(bus.i_rd_rt_ex), .ex_wr(bus.i_regwrite_ex),
        .ex_memread(bus.i_memread_ex), .mem_dst(mem_dst_q), .mem_wr(mem_wr_q),
        .sel(sel_b_c)
    );

    // Only one stall per load: the STALL state masks a hazard that is still visible.
    always_comb begin
        hazard = bus.i_memread_ex && bus.i_regwrite_ex && (bus.i_rd_rt_ex != '0) &&
                 ((bus.i_rd_rt_ex == bus.i_rs_id) ||
                  (bus.i_use_rt_id && (bus.i_rd_rt_ex == bus.i_rt_id)));
        stall  = hazard && (state_q == ST_RUN) && !bus.i_flush && !i_reset;
    end

    always_comb begin
        state_d   = state_q;
        mem_dst_d = mem_dst_q;
        mem_wr_d  = mem_wr_q;
        wb_dst_d  = wb_dst_q;
        wb_wr_d   = wb_wr_q;
        sel_a_d   = sel_a_q;
        sel_b_d   = sel_b_q;
        cnt_d     = cnt_q;
        if (bus.i_enable) begin
            mem_dst_d = bus.i_rd_rt_ex;
            mem_wr_d  = bus.i_regwrite_ex;
            wb_dst_d  = mem_dst_q;
            wb_wr_d   = mem_wr_q;
            sel_a_d   = (bus.i_flush || stall) ? FWD_REG : sel_a_c;
            sel_b_d   = (bus.i_flush || stall) ? FWD_REG : sel_b_c;
            case (state_q)
                ST_RUN:   state_d = stall ? ST_STALL : ST_RUN;
                default:  state_d = ST_RUN;
            endcase
            if (stall && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= ST_RUN;
            mem_dst_q <= '0;
            mem_wr_q  <= 1'b0;
            wb_dst_q  <= '0;
            wb_wr_q   <= 1'b0;
            sel_a_q   <= FWD_REG;
            sel_b_q   <= FWD_REG;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            mem_dst_q <= mem_dst_d;
            mem_wr_q  <= mem_wr_d;
            wb_dst_q  <= wb_dst_d;
            wb_wr_q   <= wb_wr_d;
            sel_a_q   <= sel_a_d;
            sel_b_q   <= sel_b_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.o_cortocircuitoA = sel_a_q;
    assign bus.o_cortocircuitoB = sel_b_q;
    assign bus.o_stall          = stall;
    assign bus.o_bubble         = stall;
    assign bus.o_stall_count    = cnt_q;
endmodule
